// File: rtl/sdram_fb_arbiter_if.sv
// rtl/sdram_fb_arbiter_if.sv - bundled video, writer and SDRAM-port signals for the framebuffer arbiter
// Purpose: groups every handshake/bus signal of sdram_fb_arbiter so the design and its
//   environment connect through a single port.
// Ports (signals):
//   video : vid_req, vid_addr -> arbiter; vid_ack, vid_rvalid, vid_rdata, vid_done <- arbiter
//   writer: wr_valid, wr_addr, wr_data -> arbiter; wr_ready <- arbiter
//   sdram : mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_wdata <- arbiter;
//           mem_cmd_ready, mem_rvalid, mem_rdata -> arbiter
// Modports: slave = arbiter view, master = surrounding line-buffer/writer/controller view.
interface sdram_fb_arbiter_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 16
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;
  logic              vid_done;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              mem_cmd_valid;
  logic              mem_cmd_we;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic [DATA_W-1:0] mem_cmd_wdata;
  logic              mem_cmd_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  vid_req, vid_addr, wr_valid, wr_addr, wr_data,
           mem_cmd_ready, mem_rvalid, mem_rdata,
    output vid_ack, vid_rvalid, vid_rdata, vid_done, wr_ready,
           mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_wdata
  );

  modport master (
    output vid_req, vid_addr, wr_valid, wr_addr, wr_data,
           mem_cmd_ready, mem_rvalid, mem_rdata,
    input  vid_ack, vid_rvalid, vid_rdata, vid_done, wr_ready,
           mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_wdata
  );
endinterface

// File: rtl/sdram_fb_arbiter.sv
// rtl/sdram_fb_arbiter.sv - video-priority SDRAM port arbiter with a one-write fairness token
// Purpose: shares one SDRAM command/read-data port between BURST-word video line fetches
//   (priority, real-time) and single-word framebuffer writes. A write that was pending when a
//   video burst was granted is owed the next grant, so the writer waits at most one burst.
// Ports:
//   clk   : system clock (clk_100mhz)
//   reset : asynchronous, active-low reset
//   bus   : sdram_fb_arbiter_if.slave - video request/read path, writer handshake, SDRAM port
module sdram_fb_arbiter #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 16,
  parameter int BURST  = 8
) (
  input logic               clk,
  input logic               reset,
  sdram_fb_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_VID_RD = 2'd1;
  localparam logic [1:0] S_WR_CMD = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cmd_cnt_q, cmd_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              we_q, we_d;
  logic              wr_owed_q, wr_owed_d;
  logic              vid_ack_q, vid_ack_d;
  logic              wr_ready_q, wr_ready_d;
  logic              rvalid_q, rvalid_d;
  logic              done_q, done_d;
  logic              cmd_fire;
  logic              grant_wr;
  logic              grant_vid;

  assign cmd_fire  = cmd_valid_q && bus.mem_cmd_ready;
  // An owed write beats video; otherwise video beats a fresh write.
  assign grant_wr  = bus.wr_valid && (wr_owed_q || !bus.vid_req);
  assign grant_vid = bus.vid_req && !(wr_owed_q && bus.wr_valid);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    cmd_cnt_d   = cmd_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    cmd_valid_d = cmd_valid_q;
    we_d        = we_q;
    wr_owed_d   = wr_owed_q;
    vid_ack_d   = 1'b0;
    wr_ready_d  = 1'b0;
    rvalid_d    = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_wr) begin
          wr_ready_d  = 1'b1;
          addr_d      = bus.wr_addr;
          wdata_d     = bus.wr_data;
          wr_owed_d   = 1'b0;
          we_d        = 1'b1;
          cmd_valid_d = 1'b1;
          state_d     = S_WR_CMD;
        end else if (grant_vid) begin
          vid_ack_d   = 1'b1;
          addr_d      = bus.vid_addr;
          cmd_cnt_d   = '0;
          rd_cnt_d    = '0;
          we_d        = 1'b0;
          cmd_valid_d = 1'b1;
          state_d     = S_VID_RD;
          if (bus.wr_valid) wr_owed_d = 1'b1;
        end
      end
      S_VID_RD: begin
        // Command issue and read return run independently; the address wraps naturally.
        if (cmd_fire) begin
          cmd_cnt_d = cmd_cnt_q + 1'b1;
          addr_d    = addr_q + 1'b1;
          if (cmd_cnt_d == BURST_C) cmd_valid_d = 1'b0;
        end
        if (bus.mem_rvalid) begin
          rvalid_d = 1'b1;
          rdata_d  = bus.mem_rdata;
          if (rd_cnt_q != BURST_C) rd_cnt_d = rd_cnt_q + 1'b1;
        end
        // Decided on next-state counts so vid_done lands with the last vid_rvalid.
        if (cmd_cnt_d == BURST_C && rd_cnt_d == BURST_C) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WR_CMD: begin
        if (cmd_fire) begin
          cmd_valid_d = 1'b0;
          we_d        = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cmd_cnt_q   <= '0;
      rd_cnt_q    <= '0;
      cmd_valid_q <= 1'b0;
      we_q        <= 1'b0;
      wr_owed_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      wr_ready_q  <= 1'b0;
      rvalid_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cmd_cnt_q   <= cmd_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      cmd_valid_q <= cmd_valid_d;
      we_q        <= we_d;
      wr_owed_q   <= wr_owed_d;
      vid_ack_q   <= vid_ack_d;
      wr_ready_q  <= wr_ready_d;
      rvalid_q    <= rvalid_d;
      done_q      <= done_d;
    end
  end

  assign bus.vid_ack       = vid_ack_q;
  assign bus.vid_rvalid    = rvalid_q;
  assign bus.vid_rdata     = rdata_q;
  assign bus.vid_done      = done_q;
  assign bus.wr_ready      = wr_ready_q;
  assign bus.mem_cmd_valid = cmd_valid_q;
  assign bus.mem_cmd_we    = we_q;
  assign bus.mem_cmd_addr  = addr_q;
  assign bus.mem_cmd_wdata = wdata_q;
endmodule

// File: tb/tb_sdram_fb_arbiter.sv
// tb/tb_sdram_fb_arbiter.sv - directed vector bench for sdram_fb_arbiter
module tb_sdram_fb_arbiter;
  logic clk;
  logic reset;

  sdram_fb_arbiter_if #(.ADDR_W(22), .DATA_W(16)) bus ();

  sdram_fb_arbiter #(.ADDR_W(22), .DATA_W(16), .BURST(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          is_vid;
    logic [21:0] addr;
    logic [15:0] data;
    int          stall;
    bit          inject;
    int          exp_cmds;
    logic [21:0] exp_last;
    int          exp_beats;
  } vec_t;

  vec_t vecs[5];

  // SDRAM controller model: ready after 'stall' low cycles, read data 2 cycles after accept.
  int          stall_n   = 0;
  int          stall_cnt = 0;
  int          cyc       = 0;
  logic        model_rv  = 1'b0;
  logic        inj_rv    = 1'b0;
  logic [15:0] model_rdata = 16'h0;
  int          due_q[$];
  logic [15:0] dat_q[$];
  logic [21:0] log_addr[$];
  logic        log_we[$];
  logic [21:0] log_wdata_addr[$];

  assign bus.mem_rvalid = model_rv | inj_rv;
  assign bus.mem_rdata  = model_rdata;

  function automatic logic [15:0] mem_word(input logic [21:0] a);
    return a[15:0] ^ 16'hC3A5;
  endfunction

  always @(negedge clk) begin
    cyc++;
    model_rv = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      model_rv    = 1'b1;
      model_rdata = dat_q[0];
      void'(due_q.pop_front());
      void'(dat_q.pop_front());
    end
    bus.mem_cmd_ready = 1'b0;
    if (bus.mem_cmd_valid) begin
      if (stall_cnt < stall_n) begin
        stall_cnt++;
      end else begin
        bus.mem_cmd_ready = 1'b1;
        stall_cnt = 0;
        log_addr.push_back(bus.mem_cmd_addr);
        log_we.push_back(bus.mem_cmd_we);
        if (!bus.mem_cmd_we) begin
          due_q.push_back(cyc + 2);
          dat_q.push_back(mem_word(bus.mem_cmd_addr));
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vid_ack"},   32'(bus.vid_ack),       32'h0);
    chk({tag, "_vid_rvalid"},32'(bus.vid_rvalid),    32'h0);
    chk({tag, "_vid_done"},  32'(bus.vid_done),      32'h0);
    chk({tag, "_vid_rdata"}, 32'(bus.vid_rdata),     32'h0);
    chk({tag, "_wr_ready"},  32'(bus.wr_ready),      32'h0);
    chk({tag, "_cmd_valid"}, 32'(bus.mem_cmd_valid), 32'h0);
    chk({tag, "_cmd_we"},    32'(bus.mem_cmd_we),    32'h0);
    chk({tag, "_cmd_addr"},  32'(bus.mem_cmd_addr),  32'h0);
    chk({tag, "_cmd_wdata"}, 32'(bus.mem_cmd_wdata), 32'h0);
  endtask

  task automatic run_vid(input vec_t v, input int idx);
    int acks = 0, beats = 0, dones = 0, aligned = 0, base, seq_ok = 1;
    logic [21:0] a;
    base = log_addr.size();
    stall_n = v.stall;
    bus.vid_addr = v.addr;
    bus.vid_req  = 1'b1;
    for (int c = 0; c < 400 && dones == 0; c++) begin
      @(negedge clk);
      if (bus.vid_ack) begin
        acks++;
        bus.vid_req  = 1'b0;
        bus.vid_addr = 22'h0;
      end
      if (bus.vid_rvalid) begin
        a = v.addr + 22'(beats);
        chk($sformatf("v%0d_rdata%0d", idx, beats), 32'(bus.vid_rdata), 32'(mem_word(a)));
        beats++;
      end
      if (bus.vid_done) begin
        dones++;
        aligned = (bus.vid_rvalid && beats == v.exp_beats) ? 1 : 0;
      end
    end
    chk($sformatf("v%0d_acks", idx), 32'(acks), 32'h1);
    chk($sformatf("v%0d_beats", idx), 32'(beats), 32'(v.exp_beats));
    chk($sformatf("v%0d_done", idx), 32'(dones), 32'h1);
    chk($sformatf("v%0d_done_align", idx), 32'(aligned), 32'h1);
    chk($sformatf("v%0d_cmds", idx), 32'(log_addr.size() - base), 32'(v.exp_cmds));
    if (log_addr.size() > base)
      chk($sformatf("v%0d_last_addr", idx), 32'(log_addr[log_addr.size()-1]), 32'(v.exp_last));
    for (int i = 0; i < log_addr.size() - base; i++)
      if (log_addr[base+i] !== v.addr + 22'(i) || log_we[base+i] !== 1'b0) seq_ok = 0;
    chk($sformatf("v%0d_addr_seq", idx), 32'(seq_ok), 32'h1);
  endtask

  task automatic run_wr(input vec_t v, input int idx);
    int rdys = 0, held = 0, stable = 1, fin = 0, base, inj_pend = 0;
    base = log_addr.size();
    stall_n = v.stall;
    bus.wr_addr  = v.addr;
    bus.wr_data  = v.data;
    bus.wr_valid = 1'b1;
    for (int c = 0; c < 100 && fin == 0; c++) begin
      @(negedge clk);
      if (inj_pend == 1) begin
        chk($sformatf("w%0d_rvalid_in_wr", idx), 32'(bus.vid_rvalid), 32'h0);
        inj_rv   = 1'b0;
        inj_pend = 0;
      end
      if (bus.wr_ready) begin
        rdys++;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = ~v.addr;
        bus.wr_data  = ~v.data;
        if (v.inject) begin
          inj_rv   = 1'b1;
          inj_pend = 1;
        end
      end
      if (bus.mem_cmd_valid) begin
        held++;
        if (bus.mem_cmd_addr !== v.addr || bus.mem_cmd_wdata !== v.data || bus.mem_cmd_we !== 1'b1)
          stable = 0;
      end else if (held > 0) begin
        fin = 1;
      end
    end
    inj_rv = 1'b0;
    chk($sformatf("w%0d_ready_pulses", idx), 32'(rdys), 32'h1);
    chk($sformatf("w%0d_held", idx), 32'(held), 32'(v.exp_beats));
    chk($sformatf("w%0d_stable", idx), 32'(stable), 32'h1);
    chk($sformatf("w%0d_cmds", idx), 32'(log_addr.size() - base), 32'(v.exp_cmds));
    if (log_addr.size() > base) begin
      chk($sformatf("w%0d_addr", idx), 32'(log_addr[log_addr.size()-1]), 32'(v.exp_last));
      chk($sformatf("w%0d_we", idx), 32'(log_we[log_we.size()-1]), 32'h1);
    end
  endtask

  initial begin
    int order[$];
    int dones, base, code, late, got;
    logic [21:0] wr_seen;

    vecs[0] = '{1'b1, 22'h000100, 16'h0000, 0, 1'b0, 8, 22'h000107, 8};
    vecs[1] = '{1'b0, 22'h3FFFFF, 16'hA5A5, 3, 1'b1, 1, 22'h3FFFFF, 4};
    vecs[2] = '{1'b1, 22'h3FFFFC, 16'h0000, 0, 1'b0, 8, 22'h000003, 8};
    vecs[3] = '{1'b0, 22'h012345, 16'h5A5A, 0, 1'b0, 1, 22'h012345, 1};
    vecs[4] = '{1'b1, 22'h0ABCDE, 16'h0000, 1, 1'b0, 8, 22'h0ABCE5, 8};

    reset        = 1'b0;
    bus.vid_req  = 1'b0;
    bus.vid_addr = 22'h0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = 22'h0;
    bus.wr_data  = 16'h0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].is_vid) run_vid(vecs[i], i);
      else                run_wr(vecs[i], i);
      @(negedge clk);
    end

    // Simultaneous requests: video, then the owed write despite vid_req held, then video.
    stall_n = 0;
    base = log_addr.size();
    dones = 0;
    bus.vid_addr = 22'h000200;
    bus.vid_req  = 1'b1;
    bus.wr_addr  = 22'h000055;
    bus.wr_data  = 16'hBEEF;
    bus.wr_valid = 1'b1;
    for (int c = 0; c < 600 && dones < 2; c++) begin
      @(negedge clk);
      if (bus.vid_ack) begin
        order.push_back(1);
        if (order.size() >= 3) bus.vid_req = 1'b0;
      end
      if (bus.wr_ready) begin
        order.push_back(2);
        bus.wr_valid = 1'b0;
      end
      if (bus.vid_done) dones++;
    end
    bus.vid_req  = 1'b0;
    bus.wr_valid = 1'b0;
    code = (order.size() >= 3) ? (order[0] * 256 + order[1] * 16 + order[2]) : 0;
    chk("arb_order", 32'(code), 32'h121);
    chk("arb_bursts", 32'(dones), 32'h2);
    wr_seen = 22'h3FFFFF;
    for (int i = base; i < log_addr.size(); i++)
      if (log_we[i] === 1'b1) wr_seen = log_addr[i];
    chk("arb_wr_addr", 32'(wr_seen), 32'h55);
    repeat (30) @(negedge clk);

    // Read data with no burst in flight is dropped.
    inj_rv = 1'b1;
    @(negedge clk);
    inj_rv = 1'b0;
    chk("idle_rvalid_dropped", 32'(bus.vid_rvalid), 32'h0);
    @(negedge clk);

    // Reset in the middle of a burst, after three accepted reads.
    stall_n = 0;
    base = log_addr.size();
    bus.vid_addr = 22'h000040;
    bus.vid_req  = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      @(negedge clk);
      if (bus.vid_ack) got = 1;
    end
    chk("abort_ack", 32'(got), 32'h1);
    bus.vid_req = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1 chk_zero("rst_mid");
    chk("abort_cmds", 32'(log_addr.size() - base), 32'h3);
    @(negedge clk);
    reset = 1'b1;
    late = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.vid_rvalid || bus.vid_done) late++;
    end
    chk("late_rvalid_dropped", 32'(late), 32'h0);
    bus.vid_addr = 22'h000080;
    bus.vid_req  = 1'b1;
    @(negedge clk);
    chk("ack_after_reset", 32'(bus.vid_ack), 32'h1);
    bus.vid_req = 1'b0;
    got = 0;
    for (int c = 0; c < 100 && got == 0; c++) begin
      @(negedge clk);
      if (bus.vid_done) got = 1;
    end
    chk("burst_after_reset_done", 32'(got), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
